// File: rtl/mux_salida_blink.sv
// rtl/mux_salida_blink.sv - registered group selector with field blink masking for the RTC display path
module mux_salida_blink #(
  parameter int          N         = 8,
  parameter int          G         = 3,
  parameter int          GW        = 2,
  parameter int          BLINK_DIV = 25,
  parameter int unsigned BLANK     = 32'hFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [G-1:0]     grp_sel,
  input  logic [3*G*N-1:0] grp_data,
  input  logic             edit_en,
  input  logic [1:0]       edit_field,
  output logic [N-1:0]     dato_1,
  output logic [N-1:0]     dato_2,
  output logic [N-1:0]     dato_3,
  output logic [GW-1:0]    grp_id,
  output logic             valid,
  output logic             grp_chg
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [N-1:0]  BLANK_N = N'(BLANK);
  localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);

  typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_t;

  blink_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          edit_en_q;
  logic [1:0]    field_q;
  logic          restart;

  // Live captured fields; the outputs are these with masking applied.
  logic [N-1:0]  cap [3];
  logic [N-1:0]  cap_nx [3];
  logic [GW-1:0] idx;
  logic          hit;

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int g = G - 1; g >= 0; g--) begin
      if (grp_sel[g]) begin
        idx = GW'(g);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cap_nx[k] = hit ? grp_data[(32'(idx) * 3 + k) * N +: N] : cap[k];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    restart  = !edit_en || !edit_en_q || (edit_field != field_q);
    if (restart) begin
      state_nx = SHOW;
      cnt_nx   = '0;
    end else if (tick) begin
      if (cnt == CNT_TOP) begin
        cnt_nx   = '0;
        state_nx = (state == SHOW) ? HIDE : SHOW;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SHOW;
      cnt       <= '0;
      edit_en_q <= 1'b0;
      field_q   <= 2'd0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      edit_en_q <= edit_en;
      field_q   <= edit_field;
    end
  end

  // Mask decision uses the next blink state so it lands in the same register stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) cap[k] <= '0;
      dato_1  <= '0;
      dato_2  <= '0;
      dato_3  <= '0;
      grp_id  <= '0;
      valid   <= 1'b0;
      grp_chg <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) cap[k] <= cap_nx[k];
      dato_1  <= (state_nx == HIDE && edit_en && edit_field == 2'd1) ? BLANK_N : cap_nx[0];
      dato_2  <= (state_nx == HIDE && edit_en && edit_field == 2'd2) ? BLANK_N : cap_nx[1];
      dato_3  <= (state_nx == HIDE && edit_en && edit_field == 2'd3) ? BLANK_N : cap_nx[2];
      grp_chg <= hit && (idx != grp_id || !valid);
      if (hit) begin
        grp_id <= idx;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_salida_blink.sv
// tb/tb_mux_salida_blink.sv - directed self-checking bench for mux_salida_blink
module tb_mux_salida_blink;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [2:0]  grp_sel;
  logic [71:0] grp_data;
  logic        edit_en;
  logic [1:0]  edit_field;
  logic [7:0]  dato_1, dato_2, dato_3;
  logic [1:0]  grp_id;
  logic        valid, grp_chg;

  int checks = 0;
  int errors = 0;

  mux_salida_blink #(.N(8), .G(3), .GW(2), .BLINK_DIV(2), .BLANK(32'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .grp_sel(grp_sel), .grp_data(grp_data),
    .edit_en(edit_en), .edit_field(edit_field), .dato_1(dato_1), .dato_2(dato_2),
    .dato_3(dato_3), .grp_id(grp_id), .valid(valid), .grp_chg(grp_chg)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3, input logic [1:0] id, input logic v, input logic c);
    chk({tag, ".dato_1"}, 32'(dato_1), 32'(d1));
    chk({tag, ".dato_2"}, 32'(dato_2), 32'(d2));
    chk({tag, ".dato_3"}, 32'(dato_3), 32'(d3));
    chk({tag, ".grp_id"}, 32'(grp_id), 32'(id));
    chk({tag, ".valid"},  32'(valid),  32'(v));
    chk({tag, ".grp_chg"}, 32'(grp_chg), 32'(c));
  endtask

  initial begin
    reset_n    = 1'b0;
    tick       = 1'b1;
    grp_sel    = 3'b111;
    edit_en    = 1'b1;
    edit_field = 2'd1;
    // {group2, group1, group0}, each {dato_3, dato_2, dato_1}
    grp_data   = {8'hCC, 8'hBB, 8'hAA, 8'h65, 8'h43, 8'h21, 8'h56, 8'h34, 8'h12};
    cyc();
    cyc();
    chk_out("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);

    reset_n = 1'b1; tick = 1'b0; grp_sel = 3'b000; edit_en = 1'b0; edit_field = 2'd0;
    cyc();
    chk_out("idle_after_reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);

    grp_sel = 3'b001;
    cyc();
    chk_out("first_capture_g0", 8'h12, 8'h34, 8'h56, 2'd0, 1'b1, 1'b1);
    cyc();
    chk_out("same_group_no_chg", 8'h12, 8'h34, 8'h56, 2'd0, 1'b1, 1'b0);

    grp_sel = 3'b110;
    cyc();
    chk_out("select_g1", 8'h21, 8'h43, 8'h65, 2'd1, 1'b1, 1'b1);
    grp_sel = 3'b101;
    cyc();
    chk_out("lowest_wins_g0", 8'h12, 8'h34, 8'h56, 2'd0, 1'b1, 1'b1);
    grp_sel = 3'b000;
    cyc();
    chk_out("hold", 8'h12, 8'h34, 8'h56, 2'd0, 1'b1, 1'b0);

    grp_data[23:0] = {8'h99, 8'h88, 8'h77};
    cyc();
    chk_out("data_change_held", 8'h12, 8'h34, 8'h56, 2'd0, 1'b1, 1'b0);

    edit_en = 1'b1; edit_field = 2'd2;
    cyc();
    chk("blink_start.dato_2", 32'(dato_2), 32'h34);
    tick = 1'b1;
    cyc();
    chk("tick1.dato_2", 32'(dato_2), 32'h34);
    cyc();
    chk_out("tick2_hidden", 8'h12, 8'hFF, 8'h56, 2'd0, 1'b1, 1'b0);
    tick = 1'b0;
    cyc();
    chk("hide_no_tick.dato_2", 32'(dato_2), 32'hFF);
    tick = 1'b1;
    cyc();
    chk("tick3.dato_2", 32'(dato_2), 32'hFF);
    cyc();
    chk_out("tick4_shown", 8'h12, 8'h34, 8'h56, 2'd0, 1'b1, 1'b0);

    cyc();
    cyc();
    chk("rehide.dato_2", 32'(dato_2), 32'hFF);
    edit_field = 2'd3;
    cyc();
    chk("field_chg.dato_2", 32'(dato_2), 32'h34);
    chk("field_chg.dato_3", 32'(dato_3), 32'h56);
    edit_field = 2'd3;
    cyc();
    chk("cnt_restarted.dato_3", 32'(dato_3), 32'h56);
    cyc();
    chk("field3_hidden.dato_3", 32'(dato_3), 32'hFF);
    chk("field3_hidden.dato_1", 32'(dato_1), 32'h12);
    tick = 1'b0; edit_en = 1'b0;
    cyc();
    chk("edit_off.dato_3", 32'(dato_3), 32'h56);

    grp_sel = 3'b100;
    cyc();
    chk_out("select_g2", 8'hAA, 8'hBB, 8'hCC, 2'd2, 1'b1, 1'b1);
    grp_sel = 3'b000;
    reset_n = 1'b0;
    #2;
    chk_out("async_reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    cyc();
    reset_n = 1'b1; grp_sel = 3'b001;
    cyc();
    chk_out("post_reset_capture", 8'h77, 8'h88, 8'h99, 2'd0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
